// File: rtl/adc_lvds_pkg.sv
// ---------------------------------------------------------------------------
// adc_lvds_pkg
// Shared definitions for the LVDS ADC lane (transmit emulator, receive lane,
// frame aligner).
//   ADC_TRAIN_DEFAULT : default training word (low AdcBits are used)
//   adc_bits_legal()  : 1 when a sample width is supported (8/10/12/14)
//   frm_word()        : frame-clock pattern for one word, MSB-first;
//                       upper half of the word is 1, lower half is 0
//   delay_width()     : width of the injected bit-delay counter
// ---------------------------------------------------------------------------
package adc_lvds_pkg;

  localparam logic [15:0] ADC_TRAIN_DEFAULT = 16'h2A5A;

  function automatic bit adc_bits_legal(input int bits);
    return (bits == 8) || (bits == 10) || (bits == 12) || (bits == 14);
  endfunction

  // Bit i counted from the MSB is 1 for the first bits/2 bits of the word.
  function automatic logic [15:0] frm_word(input int bits);
    logic [15:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) begin
      if ((i < bits) && (i >= bits / 2)) f[i] = 1'b1;
    end
    return f;
  endfunction

  function automatic int delay_width(input int bits);
    return $clog2(bits);
  endfunction

endpackage

// File: rtl/adc_bit_delay.sv
// ---------------------------------------------------------------------------
// adc_bit_delay
// Variable bit delay for 2-bit/clock streams. Each lane carries a rise/fall
// bit pair per clock (rise = earlier bit). The lane keeps a shift history of
// past bits and picks the pair that lies i_delay bit-times in the past, so a
// delay change by one repeats a single bit instead of dropping one.
// Ports:
//   i_clk    clock, rising edge
//   i_srst   synchronous reset, active-high: history and outputs cleared
//   i_bits   per lane gi: {i_bits[2gi+1] rise, i_bits[2gi] fall}
//   i_delay  delay in bit-times (0 .. HistBits)
//   o_bits   delayed pairs, registered, same packing as i_bits
// ---------------------------------------------------------------------------
module adc_bit_delay
  import adc_lvds_pkg::*;
#(
  parameter int Lanes    = 2,
  parameter int HistBits = 28,
  parameter int DelayW   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_srst,
  input  logic [2*Lanes-1:0]   i_bits,
  input  logic [DelayW-1:0]    i_delay,
  output logic [2*Lanes-1:0]   o_bits
);

  genvar gi;
  generate
    for (gi = 0; gi < Lanes; gi++) begin : g_lane
      logic [HistBits-1:0] r_hist;
      logic [1:0]          r_out;
      logic [HistBits+1:0] w_x;

      // w_x[0] is the newest (fall) bit, w_x[1] the rise bit of this clock,
      // w_x[j] the bit j bit-times older than the current fall bit.
      assign w_x = {r_hist, i_bits[2*gi+1], i_bits[2*gi]};

      always_ff @(posedge i_clk) begin
        if (i_srst) begin
          r_hist <= '0;
          r_out  <= '0;
        end else begin
          r_hist <= w_x[HistBits-1:0];
          r_out  <= 2'(w_x >> i_delay);
        end
      end

      assign o_bits[2*gi+1 -: 2] = r_out;
    end
  endgenerate

endmodule

// File: rtl/adc_lane_tx.sv
// ---------------------------------------------------------------------------
// adc_lane_tx
// Transmit side of the LVDS ADC lane, used as an ADC emulator for loopback.
// Samples are serialised MSB-first, two bits per clock (rise/fall pair for an
// external ODDR), together with the frame-clock bits. Bit skew can be injected
// one bit at a time (inverse of receiver bitslip) and a training word can be
// substituted for the sample.
// Ports:
//   DatClk      bit-pair clock, rising edge
//   DatRst      synchronous reset, active-high
//   TxData      16-bit sample, low AdcBits transmitted
//   TxValid     TxData valid
//   TxReady     load beat; a word is taken on the edge where it is high
//   TxTrain     at load beat: send AdcTrain instead of TxData
//   TxSlip      pulse: add one bit-time of delay (wraps at AdcBits-1)
//   TxDelay     current injected delay in bit-times
//   TxUnderrun  load beat with neither TxValid nor TxTrain (zero word sent)
//   DatBitRise/DatBitFall, FrmBitRise/FrmBitFall  line bit pairs
// Latency: word taken at edge n -> MSB on DatBitRise after edge n+2 (delay 0).
// ---------------------------------------------------------------------------
module adc_lane_tx
  import adc_lvds_pkg::*;
#(
  parameter int          AdcBits   = 14,
  parameter bit          AdcInvert = 1'b0,
  parameter logic [15:0] AdcTrain  = ADC_TRAIN_DEFAULT
) (
  input  logic                       DatClk,
  input  logic                       DatRst,
  input  logic [15:0]                TxData,
  input  logic                       TxValid,
  output logic                       TxReady,
  input  logic                       TxTrain,
  input  logic                       TxSlip,
  output logic [$clog2(AdcBits)-1:0] TxDelay,
  output logic                       TxUnderrun,
  output logic                       DatBitRise,
  output logic                       DatBitFall,
  output logic                       FrmBitRise,
  output logic                       FrmBitFall
);

  localparam int                 Half      = AdcBits / 2;
  localparam int                 BeatW     = $clog2(Half);
  localparam int                 DelayW    = delay_width(AdcBits);
  localparam int                 HistBits  = 2 * AdcBits;
  localparam logic [15:0]        FrmFull   = frm_word(AdcBits);
  localparam logic [AdcBits-1:0] FrmWord   = FrmFull[AdcBits-1:0];
  localparam logic [AdcBits-1:0] TrainWord = AdcTrain[AdcBits-1:0];
  localparam logic [BeatW-1:0]   LastBeat  = BeatW'(Half - 1);
  localparam logic [DelayW-1:0]  MaxDelay  = DelayW'(AdcBits - 1);

  generate
    if (!adc_bits_legal(AdcBits)) begin : g_bad_bits
      $error("adc_lane_tx: AdcBits must be 8, 10, 12 or 14");
    end
  endgenerate

  logic [BeatW-1:0]   r_beat;
  logic [AdcBits-1:0] r_word;
  logic [3:0]         r_raw;      // {data rise, data fall, frame rise, frame fall}
  logic [DelayW-1:0]  r_delay;

  logic               w_load;
  logic [AdcBits-1:0] w_word_next;
  logic [AdcBits-1:0] w_dat_sh;
  logic [AdcBits-1:0] w_frm_sh;
  logic [1:0]         w_dat_pair;
  logic [1:0]         w_frm_pair;
  logic [3:0]         w_line;
  logic               w_unused_hi;

  // Only the low AdcBits of the sign-extended sample go on the line.
  assign w_unused_hi = ^TxData[15:AdcBits];

  // Reset gates the load beat so nothing is accepted while DatRst is high.
  assign w_load = (r_beat == LastBeat) && !DatRst;

  always_comb begin
    w_word_next = '0;
    if (TxTrain) begin
      w_word_next = TrainWord;
    end else if (TxValid) begin
      w_word_next = TxData[AdcBits-1:0];
    end
  end

  // Shift the current beat's pair to the top of the word, then take it.
  assign w_dat_sh   = r_word << {r_beat, 1'b0};
  assign w_frm_sh   = FrmWord << {r_beat, 1'b0};
  assign w_dat_pair = 2'(w_dat_sh >> (AdcBits - 2)) ^ {2{AdcInvert}};
  assign w_frm_pair = 2'(w_frm_sh >> (AdcBits - 2));

  always_ff @(posedge DatClk) begin
    if (DatRst) begin
      r_beat  <= LastBeat;
      r_word  <= '0;
      r_raw   <= '0;
      r_delay <= '0;
    end else begin
      r_beat <= (r_beat == LastBeat) ? '0 : r_beat + BeatW'(1);
      if (w_load) begin
        r_word <= w_word_next;
      end
      r_raw <= {w_dat_pair, w_frm_pair};
      if (TxSlip) begin
        r_delay <= (r_delay == MaxDelay) ? '0 : r_delay + DelayW'(1);
      end
    end
  end

  adc_bit_delay #(
    .Lanes    (2),
    .HistBits (HistBits),
    .DelayW   (DelayW)
  ) u_delay (
    .i_clk   (DatClk),
    .i_srst  (DatRst),
    .i_bits  (r_raw),
    .i_delay (r_delay),
    .o_bits  (w_line)
  );

  assign {DatBitRise, DatBitFall, FrmBitRise, FrmBitFall} = w_line;
  assign TxReady    = w_load;
  assign TxUnderrun = w_load && !TxValid && !TxTrain;
  assign TxDelay    = r_delay;

endmodule

// File: tb/tb_adc_lane_tx.sv
// ---------------------------------------------------------------------------
// tb_adc_lane_tx
// Directed bench for adc_lane_tx (AdcBits=14) with a second instance built
// with AdcInvert=1. A bit-stream model places every accepted word at its
// absolute bit time on the line and derives each output pair from the
// current delay; literal expectations pin the model on known words.
// ---------------------------------------------------------------------------
module tb_adc_lane_tx;

  localparam int AB = 14;
  localparam int H  = AB / 2;
  localparam int NB = 4096;

  logic        DatClk = 1'b0;
  logic        DatRst, TxValid, TxTrain, TxSlip;
  logic [15:0] TxData;
  logic        TxReady, TxUnderrun, DatBitRise, DatBitFall, FrmBitRise, FrmBitFall;
  logic [3:0]  TxDelay;
  logic        TxReady_i, TxUnderrun_i, DatBitRise_i, DatBitFall_i, FrmBitRise_i, FrmBitFall_i;
  logic [3:0]  TxDelay_i;

  always #5 DatClk = ~DatClk;

  adc_lane_tx #(.AdcBits(AB), .AdcInvert(1'b0), .AdcTrain(16'h2A5A)) dut (
    .DatClk(DatClk), .DatRst(DatRst), .TxData(TxData), .TxValid(TxValid),
    .TxReady(TxReady), .TxTrain(TxTrain), .TxSlip(TxSlip), .TxDelay(TxDelay),
    .TxUnderrun(TxUnderrun), .DatBitRise(DatBitRise), .DatBitFall(DatBitFall),
    .FrmBitRise(FrmBitRise), .FrmBitFall(FrmBitFall)
  );

  adc_lane_tx #(.AdcBits(AB), .AdcInvert(1'b1), .AdcTrain(16'h2A5A)) dut_inv (
    .DatClk(DatClk), .DatRst(DatRst), .TxData(TxData), .TxValid(TxValid),
    .TxReady(TxReady_i), .TxTrain(TxTrain), .TxSlip(TxSlip), .TxDelay(TxDelay_i),
    .TxUnderrun(TxUnderrun_i), .DatBitRise(DatBitRise_i), .DatBitFall(DatBitFall_i),
    .FrmBitRise(FrmBitRise_i), .FrmBitFall(FrmBitFall_i)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- stream model ----------------
  bit   m_dat[NB];
  bit   m_frm[NB];
  bit   m_cov[NB];
  int   cyc = 0;
  int   m_since = 0;   // clocks since reset release; words start every H clocks
  int   m_delay = 0;
  bit   m_started = 0;
  logic [1:0] e_dat = '0;
  logic [1:0] e_frm = '0;
  bit   e_cov_r = 0;
  bit   e_cov_f = 0;
  bit   exp_ready;

  function automatic bit get_dat(input int t);
    if (t < 0 || t >= NB) return 1'b0;
    return m_dat[t];
  endfunction
  function automatic bit get_frm(input int t);
    if (t < 0 || t >= NB) return 1'b0;
    return m_frm[t];
  endfunction
  function automatic bit get_cov(input int t);
    if (t < 0 || t >= NB) return 1'b0;
    return m_cov[t];
  endfunction

  // Output pair after edge e carries line bit times 2e (rise) and 2e+1 (fall),
  // i.e. raw stream bits 2e-d and 2e+1-d. A word taken at edge n occupies raw
  // bit times 2(n+2) .. 2(n+2)+AB-1, MSB first.
  always @(posedge DatClk) begin : p_model
    int t;
    int tr;
    logic [13:0] w;
    m_started = 1'b1;
    if (DatRst) begin
      for (int k = 0; k < NB; k++) begin
        m_dat[k] = 1'b0;
        m_frm[k] = 1'b0;
        m_cov[k] = 1'b0;
      end
      m_since = 0;
      m_delay = 0;
      e_dat   = '0;
      e_frm   = '0;
      e_cov_r = 1'b0;
      e_cov_f = 1'b0;
    end else begin
      if (m_since % H == 0) begin
        if (TxTrain)      w = 14'h2A5A;
        else if (TxValid) w = TxData[13:0];
        else              w = '0;
        for (int j = 0; j < AB; j++) begin
          t = 2 * (cyc + 2) + j;
          if (t < NB) begin
            m_dat[t] = w[AB-1-j];
            m_frm[t] = (j < H);
            m_cov[t] = 1'b1;
          end
        end
      end
      m_since++;
      tr      = 2 * cyc - m_delay;
      e_dat   = {get_dat(tr), get_dat(tr + 1)};
      e_frm   = {get_frm(tr), get_frm(tr + 1)};
      e_cov_r = get_cov(tr);
      e_cov_f = get_cov(tr + 1);
      if (TxSlip) m_delay = (m_delay == AB - 1) ? 0 : m_delay + 1;
    end
    cyc++;
  end

  always @(negedge DatClk) begin
    if (m_started) begin
      exp_ready = !DatRst && (m_since % H == 0);
      chk("ready", TxReady, exp_ready);
      chk("underrun", TxUnderrun, exp_ready && !TxValid && !TxTrain);
      chk("dat_pair", {DatBitRise, DatBitFall}, e_dat);
      chk("frm_pair", {FrmBitRise, FrmBitFall}, e_frm);
      chk("delay", TxDelay, m_delay);
      chk("inv_ready", TxReady_i, exp_ready);
      chk("inv_frm_pair", {FrmBitRise_i, FrmBitFall_i}, e_frm);
      chk("inv_delay", TxDelay_i, m_delay);
      if (e_cov_r) chk("inv_dat_rise", DatBitRise_i, !e_dat[1]);
      if (e_cov_f) chk("inv_dat_fall", DatBitFall_i, !e_dat[0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge DatClk);
    #1;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 2 * H && TxReady !== 1'b1; k++) step();
    chk("ready_wait", TxReady, 1'b1);
  endtask

  task automatic slip();
    TxSlip = 1'b1;
    step();
    TxSlip = 1'b0;
    step();
  endtask

  // Capture the word taken at the next load beat from both instances.
  task automatic cap_word(output logic [13:0] d, output logic [13:0] f,
                          output logic [13:0] di, output logic [13:0] fi);
    d = '0; f = '0; di = '0; fi = '0;
    wait_ready();
    step();
    step();
    for (int k = 0; k < H; k++) begin
      step();
      d  = {d[11:0], DatBitRise, DatBitFall};
      f  = {f[11:0], FrmBitRise, FrmBitFall};
      di = {di[11:0], DatBitRise_i, DatBitFall_i};
      fi = {fi[11:0], FrmBitRise_i, FrmBitFall_i};
    end
  endtask

  logic [69:0] cap, fcap, exp_stream, exp_fstream;
  logic [13:0] cd, cf, cdi, cfi;
  int n_rdy, n_und;

  initial begin
    DatRst = 1'b1; TxValid = 1'b0; TxTrain = 1'b0; TxSlip = 1'b0; TxData = '0;
    repeat (3) step();
    chk("rst_ready", TxReady, 1'b0);
    chk("rst_line", {DatBitRise, DatBitFall, FrmBitRise, FrmBitFall}, 4'b0);
    chk("rst_delay", TxDelay, 4'd0);

    // Back-to-back words, one underrun, then a steady 2ABC stream.
    DatRst = 1'b0; TxValid = 1'b1; TxData = 16'h2ABC;
    #1;
    chk("first_ready", TxReady, 1'b1);
    step();
    TxData = 16'h1234;
    step();
    cap = '0; fcap = '0; n_rdy = 0; n_und = 0;
    for (int i = 0; i < 5 * H; i++) begin
      step();
      cap  = {cap[67:0], DatBitRise, DatBitFall};
      fcap = {fcap[67:0], FrmBitRise, FrmBitFall};
      if (TxReady) n_rdy++;
      if (TxUnderrun) n_und++;
      if (i == 18) chk("underrun_pulse", TxUnderrun, 1'b1);
      if (i == 5) TxData = 16'h0567;
      if (i == 12) TxValid = 1'b0;
      if (i == 19) begin
        TxValid = 1'b1;
        TxData  = 16'h2ABC;
      end
    end
    exp_stream  = {14'h2ABC, 14'h1234, 14'h0567, 14'h0000, 14'h2ABC};
    exp_fstream = {14'h3F80, 14'h3F80, 14'h3F80, 14'h3F80, 14'h3F80};
    chk("stream_dat", cap, exp_stream);
    chk("stream_frm", fcap, exp_fstream);
    chk("ready_count", n_rdy, 5);
    chk("underrun_count", n_und, 1);

    // Three slips: both streams three bits late.
    repeat (3) slip();
    chk("delay_3", TxDelay, 4'd3);
    cap_word(cd, cf, cdi, cfi);
    chk("slip3_dat", cd, 14'h2557);
    chk("slip3_frm", cf, 14'h07F0);

    // Eleven more: 14 in total wraps to zero.
    repeat (11) slip();
    chk("delay_wrap", TxDelay, 4'd0);

    // Training word on both builds.
    TxTrain = 1'b1;
    cap_word(cd, cf, cdi, cfi);
    chk("train_dat", cd, 14'h2A5A);
    chk("train_frm", cf, 14'h3F80);
    chk("train_inv_dat", cdi, 14'h15A5);
    chk("train_inv_frm", cfi, 14'h3F80);

    // Slip on the load beat: both take effect.
    wait_ready();
    TxSlip = 1'b1;
    step();
    TxSlip = 1'b0;
    chk("slip_at_load", TxDelay, 4'd1);
    repeat (4) slip();
    chk("delay_5", TxDelay, 4'd5);
    TxTrain = 1'b0;

    // Reset in the middle of a word.
    wait_ready();
    step();
    step();
    step();
    DatRst = 1'b1;
    step();
    chk("midrst_line", {DatBitRise, DatBitFall, FrmBitRise, FrmBitFall}, 4'b0);
    chk("midrst_delay", TxDelay, 4'd0);
    chk("midrst_ready", TxReady, 1'b0);
    chk("midrst_underrun", TxUnderrun, 1'b0);
    DatRst = 1'b0;
    #1;
    chk("release_ready", TxReady, 1'b1);
    step();
    step();
    step();
    chk("release_msb_dat", {DatBitRise, DatBitFall}, 2'b10);
    chk("release_msb_frm", {FrmBitRise, FrmBitFall}, 2'b11);
    repeat (2 * H) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
